fmesh_route_ctrl: RTL

- Registered, packet-aware route-compute stage for the fmesh topology; one instance per router input port.
- Decodes the destination endpoint address carried by the head flit and computes a one-hot output port plus a remaining-hop count.
- Holds that route for every following flit until the tail, with a valid/ready handshake on both sides.
- Generalises the combinational fmesh destination-port logic: any NX/NY/NL, XY or minimal-adaptive mode, registered output, per-packet state.

---
 rtl/fmesh_pkg.sv | 31 +++
 rtl/fmesh_route_calc.sv | 87 ++++++++
 rtl/fmesh_route_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/fmesh_pkg.sv
// Shared fmesh types: port indices, address struct, route mode, log2.
// The address struct is wide enough for any supported mesh size.
package fmesh_pkg;

    localparam int LOCAL = 0;
    localparam int EAST  = 1;
    localparam int NORTH = 2;
    localparam int WEST  = 3;
    localparam int SOUTH = 4;

    localparam int AFW = 8;

    typedef struct packed {
        logic [AFW-1:0] p;
        logic [AFW-1:0] y;
        logic [AFW-1:0] x;
    } fmesh_addr_t;

    typedef enum logic {
        RT_XY,
        RT_ADAPTIVE_MIN
    } route_type_e;

    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fmesh_route_calc.sv
// Combinational fmesh route, hop count and address check for one head flit.
// Optional range check enabled by PRONOC_FMESH_ADDR_CHK_EN.
module fmesh_route_calc
    import fmesh_pkg::*;
#(
    parameter int    NX         = 4,
    parameter int    NY         = 4,
    parameter int    NL         = 2,
    parameter string ROUTE_TYPE = "XY",
    parameter int    DISTw      = 4,
    localparam int   P          = 4 + NL,
    localparam int   EXw        = log2(NX),
    localparam int   EYw        = log2(NY),
    localparam int   EPw        = log2(P),
    localparam int   EAw        = EXw + EYw + EPw
) (
    input  logic [EXw-1:0]   cur_x,
    input  logic [EYw-1:0]   cur_y,
    input  logic [EAw-1:0]   dest_addr,
    input  logic [3:0]       cong,
    input  logic             toggle,
    output logic [P-1:0]     destport,
    output logic [DISTw-1:0] hops,
    output logic             err,
    output logic             tie
);

    localparam route_type_e RT =
        (ROUTE_TYPE == "ADAPTIVE_MIN") ? RT_ADAPTIVE_MIN : RT_XY;

    fmesh_addr_t    a;
    logic [AFW-1:0] cx, cy, xd, yd;
    logic [DISTw:0] sum;
    logic           xmove, ymove, xbusy, ybusy, take_x;
    int             xport, yport, sel;

    always_comb begin
        a.p = AFW'(dest_addr[EXw+EYw +: EPw]);
        a.y = AFW'(dest_addr[EXw +: EYw]);
        a.x = AFW'(dest_addr[EXw-1:0]);
        cx  = AFW'(cur_x);
        cy  = AFW'(cur_y);

        xd  = (a.x > cx) ? a.x - cx : cx - a.x;
        yd  = (a.y > cy) ? a.y - cy : cy - a.y;
        sum = (DISTw+1)'(EXw'(xd)) + (DISTw+1)'(EYw'(yd))
            + (DISTw+1)'(1);
        hops = DISTw'(sum);

        xmove = (a.x != cx);
        ymove = (a.y != cy);
        xport = (a.x > cx) ? EAST : WEST;
        yport = (a.y > cy) ? SOUTH : NORTH;
        // cong is packed {S,W,N,E}, i.e. bit index = port - 1
        xbusy = cong[2'(xport - 1)];
        ybusy = cong[2'(yport - 1)];

        tie    = 1'b0;
        take_x = 1'b1;
        if (RT == RT_ADAPTIVE_MIN && xmove && ymove) begin
            if (xbusy == ybusy) begin
                tie    = 1'b1;
                take_x = ~toggle;
            end else begin
                take_x = ~xbusy;
            end
        end

        sel = LOCAL;
        if (xmove && take_x)
            sel = xport;
        else if (ymove)
            sel = yport;
        else
            sel = int'(a.p);
        destport = P'(1) << sel;

`ifdef PRONOC_FMESH_ADDR_CHK_EN
        err = (a.x > AFW'(NX - 1)) || (a.y > AFW'(NY - 1))
           || (a.p > AFW'(P - 1));
`else
        err = 1'b0;
`endif
        if (err) destport = '0;
    end

endmodule

// File: rtl/fmesh_route_ctrl.sv
// Registered packet-aware fmesh route stage: head flits compute a route that
// is held until the tail. Address check via PRONOC_FMESH_ADDR_CHK_EN.
module fmesh_route_ctrl
    import fmesh_pkg::*;
#(
    parameter int    NX         = 4,
    parameter int    NY         = 4,
    parameter int    NL         = 2,
    parameter string ROUTE_TYPE = "XY",
    parameter int    DISTw      = 4,
    localparam int   P          = 4 + NL,
    localparam int   EXw        = log2(NX),
    localparam int   EYw        = log2(NY),
    localparam int   EPw        = log2(P),
    localparam int   EAw        = EXw + EYw + EPw
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [EXw-1:0]   cur_x,
    input  logic [EYw-1:0]   cur_y,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_head,
    input  logic             in_tail,
    input  logic [EAw-1:0]   in_dest_addr,
    input  logic [3:0]       cong,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P-1:0]     out_destport,
    output logic [DISTw-1:0] out_hops,
    output logic             out_head,
    output logic             out_tail,
    output logic             out_err
);

    typedef enum logic { IDLE, IN_PKT } state_t;

    state_t           state;
    logic             toggle;
    logic [P-1:0]     pkt_port;
    logic [DISTw-1:0] pkt_hops;
    logic             pkt_err;

    logic [P-1:0]     calc_port;
    logic [DISTw-1:0] calc_hops;
    logic             calc_err, calc_tie, accept;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    fmesh_route_calc #(
        .NX(NX), .NY(NY), .NL(NL),
        .ROUTE_TYPE(ROUTE_TYPE), .DISTw(DISTw)
    ) u_calc (
        .cur_x(cur_x),
        .cur_y(cur_y),
        .dest_addr(in_dest_addr),
        .cong(cong),
        .toggle(toggle),
        .destport(calc_port),
        .hops(calc_hops),
        .err(calc_err),
        .tie(calc_tie)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            toggle       <= 1'b0;
            pkt_port     <= '0;
            pkt_hops     <= '0;
            pkt_err      <= 1'b0;
            out_valid    <= 1'b0;
            out_destport <= '0;
            out_hops     <= '0;
            out_head     <= 1'b0;
            out_tail     <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                out_valid <= 1'b1;
                out_head  <= in_head;
                out_tail  <= in_tail;
                // a head always restarts, even mid-packet
                if (in_head) begin
                    out_destport <= calc_port;
                    out_hops     <= calc_hops;
                    out_err      <= calc_err;
                    if (calc_tie) toggle <= ~toggle;
                    pkt_port <= calc_port;
                    pkt_hops <= calc_hops;
                    pkt_err  <= calc_err;
                    state    <= in_tail ? IDLE : IN_PKT;
                end else if (state == IN_PKT) begin
                    out_destport <= pkt_port;
                    out_hops     <= pkt_hops;
                    out_err      <= pkt_err;
                    if (in_tail) state <= IDLE;
                end else begin
                    out_destport <= '0;
                    out_hops     <= '0;
                    out_err      <= 1'b1;
                end
            end
        end
    end

endmodule
